// File: rtl/id_seq_pkg.sv
// Shared types and helpers for the id_sequencer block.
// Provides the sequencer state enum and the index-width function used to size
// idx buses from DEPTH.
package id_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Width of an index able to address DEPTH digits; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/id_sequencer_if.sv
// Control/status bundle of the id_sequencer.
// master: drives en/dir/mode/start/hold, observes id/idx/busy/wrap/done.
// slave : the sequencer itself.
interface id_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IW    = 3
);
  logic             en;
  logic             dir;
  logic             mode;
  logic             start;
  logic             hold;
  logic [WIDTH-1:0] id;
  logic [IW-1:0]    idx;
  logic             busy;
  logic             wrap;
  logic             done;

  modport master (
    output en, dir, mode, start, hold,
    input  id, idx, busy, wrap, done
  );

  modport slave (
    input  en, dir, mode, start, hold,
    output id, idx, busy, wrap, done
  );
endinterface

// File: rtl/id_sequencer_counter.sv
// seq_index_counter: mod-DEPTH up/down index counter.
// Ports: clk, reset (sync, active-high), load (reload first index for dir),
// step (advance one position per dir), dir (0 up, 1 down),
// idx (current index), idx_next (index after this edge), term (idx is the
// terminal position for the current dir).
// Wrap-around uses explicit compares so non-power-of-two DEPTH stays in range.
module seq_index_counter
  import id_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic          dir,
  output logic [IW-1:0] idx,
  output logic [IW-1:0] idx_next,
  output logic          term
);

  localparam logic [IW-1:0] Last = IW'(DEPTH - 1);

  logic [IW-1:0] idx_q;

  always_comb begin
    idx_next = idx_q;
    if (load) begin
      idx_next = dir ? Last : '0;
    end else if (step) begin
      if (dir) begin
        idx_next = (idx_q == '0) ? Last : idx_q - IW'(1);
      end else begin
        idx_next = (idx_q == Last) ? '0 : idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_next;
    end
  end

  assign idx  = idx_q;
  assign term = dir ? (idx_q == '0) : (idx_q == Last);

endmodule

// File: rtl/id_sequencer.sv
// id_sequencer: table-driven digit sequencer.
// Steps through DEPTH digits of WIDTH bits packed in SEQ (digit 0 in the MSBs),
// one digit per accepted en strobe, forward or reverse, looping or one-shot.
// Ports: clk, reset (sync, active-high), bus (id_sequencer_if.slave):
//   en/dir/mode/start/hold in; id (registered digit), idx, busy, wrap and
//   done (one-cycle pulses) out.
module id_sequencer
  import id_seq_pkg::*;
#(
  parameter int unsigned             DEPTH = 8,
  parameter int unsigned             WIDTH = 4,
  parameter logic [DEPTH*WIDTH-1:0]  SEQ   = 32'h4110_2356
) (
  input  logic           clk,
  input  logic           reset,
  id_sequencer_if.slave  bus
);

  localparam int unsigned IW = idx_width(DEPTH);

  state_e           state_q, state_d;
  logic             load, step, term;
  logic             wrap_q, wrap_d, done_q, done_d;
  logic [IW-1:0]    idx, idx_next;
  logic [WIDTH-1:0] id_q, digit;

  seq_index_counter #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .dir      (bus.dir),
    .idx      (idx),
    .idx_next (idx_next),
    .term     (term)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StRun: begin
        // start outranks en: restart without stepping.
        if (bus.start) begin
          load = 1'b1;
        end else if (bus.en && !bus.hold) begin
          if (term && bus.mode) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            step   = 1'b1;
            wrap_d = term;
          end
        end
      end
      StIdle, StDone: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Digit for the index after this edge, so id and idx update together.
  always_comb begin
    digit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (idx_next == IW'(i)) begin
        digit = SEQ[(DEPTH-1-i)*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      id_q    <= SEQ[DEPTH*WIDTH-1 -: WIDTH];
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      id_q    <= digit;
    end
  end

  assign bus.id   = id_q;
  assign bus.idx  = idx;
  assign bus.busy = (state_q == StRun);
  assign bus.wrap = wrap_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_id_sequencer.sv
module tb_id_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_sequencer_if #(.WIDTH(4), .IW(3)) bus8 ();
  id_sequencer_if #(.WIDTH(4), .IW(3)) bus5 ();

  id_sequencer #(.DEPTH(8), .WIDTH(4), .SEQ(32'h4110_2356)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  id_sequencer #(.DEPTH(5), .WIDTH(4), .SEQ(20'h12345)) u_dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: digit tables, plus abstract state (0 idle, 1 run, 2 done).
  int depth [2] = '{8, 5};
  int digits[2][8] = '{'{4, 1, 1, 0, 2, 3, 5, 6}, '{1, 2, 3, 4, 5, 0, 0, 0}};
  int m_st  [2];
  int m_idx [2];
  int m_wrap[2];
  int m_done[2];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit r, input bit s, input bit e,
                            input bit h, input bit d, input bit m);
    int first, last;
    first = d ? depth[k] - 1 : 0;
    last  = d ? 0 : depth[k] - 1;
    if (r) begin
      m_st[k] = 0; m_idx[k] = 0; m_wrap[k] = 0; m_done[k] = 0;
    end else begin
      m_wrap[k] = 0;
      m_done[k] = 0;
      if (m_st[k] != 1) begin
        if (s) begin
          m_st[k]  = 1;
          m_idx[k] = first;
        end
      end else if (s) begin
        m_idx[k] = first;
      end else if (e && !h) begin
        if (m_idx[k] == last) begin
          if (m) begin
            m_st[k]   = 2;
            m_done[k] = 1;
          end else begin
            m_idx[k]  = first;
            m_wrap[k] = 1;
          end
        end else begin
          m_idx[k] = (m_idx[k] + (d ? depth[k] - 1 : 1)) % depth[k];
        end
      end
    end
  endtask

  task automatic check_all();
    check("d8_idx",  int'(bus8.idx),  m_idx[0]);
    check("d8_id",   int'(bus8.id),   digits[0][m_idx[0]]);
    check("d8_busy", int'(bus8.busy), int'(m_st[0] == 1));
    check("d8_wrap", int'(bus8.wrap), m_wrap[0]);
    check("d8_done", int'(bus8.done), m_done[0]);
    check("d5_idx",  int'(bus5.idx),  m_idx[1]);
    check("d5_id",   int'(bus5.id),   digits[1][m_idx[1]]);
    check("d5_busy", int'(bus5.busy), int'(m_st[1] == 1));
    check("d5_wrap", int'(bus5.wrap), m_wrap[1]);
    check("d5_done", int'(bus5.done), m_done[1]);
    check("d5_range", int'(bus5.idx < 3'd5), 1);
  endtask

  // One clock: apply inputs, advance the model on the edge, check 1 time unit later.
  task automatic cyc(input bit r, input bit s, input bit e, input bit h,
                     input bit d, input bit m);
    reset = r;
    bus8.start = s; bus8.en = e; bus8.hold = h; bus8.dir = d; bus8.mode = m;
    bus5.start = s; bus5.en = e; bus5.hold = h; bus5.dir = d; bus5.mode = m;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, r, s, e, h, d, m);
    #1;
    check_all();
  endtask

  initial begin
    bit d, m;
    bus8.start = 0; bus8.en = 0; bus8.hold = 0; bus8.dir = 0; bus8.mode = 0;
    bus5.start = 0; bus5.en = 0; bus5.hold = 0; bus5.dir = 0; bus5.mode = 0;
    @(negedge clk);

    // Reset, then forward loop through a full lap plus wrap.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);                       // IDLE ignores en
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 0, 0);

    // Reverse one-shot to completion, then en ignored in DONE.
    cyc(0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 1, 1);

    // Hold mid-run at idx 3.
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);

    // Reach idx 5, start+en together, then flip dir at idx 2.
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);                       // reverse wrap 0 -> DEPTH-1

    // Reset overrides start and en mid-run.
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);

    // Randomized traffic.
    d = 0;
    m = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) d = ~d;
      if ($urandom_range(31) == 0) m = ~m;
      cyc($urandom_range(63) == 0, $urandom_range(19) == 0, $urandom_range(3) != 0,
          $urandom_range(7) == 0, d, m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
